regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 register file. It shares the file's single write port between two requesters, ALU result and memory load, using valid/ready handshakes and round-robin priority. It drives a registered write stage into the file's we/waddr/wdata. It also keeps a pending-write scoreboard so the issue stage can stall on read-after-write hazards.

Parameters:
NREG, 32, number of architectural registers
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
alu_valid  in  1  ALU write request
alu_ready  out  1  ALU request accepted this cycle
alu_waddr  in  AW  ALU destination register
alu_wdata  in  DW  ALU result
mem_valid  in  1  load write request
mem_ready  out  1  load request accepted this cycle
mem_waddr  in  AW  load destination register
mem_wdata  in  DW  load data
rsv_valid  in  1  issue stage reserves a destination
rsv_addr  in  AW  register being reserved
chk_addr1  in  AW  source operand 1 of the issuing instruction
chk_addr2  in  AW  source operand 2 of the issuing instruction
hazard  out  1  a source register has a pending write
rf_we  out  1  to register file we
rf_waddr  out  AW  to register file waddr
rf_wdata  out  DW  to register file wdata
busy  out  NREG  scoreboard, one bit per register

Behaviour:
- Reset (async, immediate): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, last_grant=MEM (so ALU wins the first tie). alu_ready and mem_ready are forced 0 while rst=1.
- Transfer: a request is accepted when valid&&ready at a rising edge. Requesters hold addr/data stable while valid&&!ready.
- Arbitration, combinational, at most one ready per cycle:
  - Only one valid: that requester gets ready.
  - Both valid: the requester that is not last_grant gets ready.
  - Neither valid: no ready.
  - last_grant updates to the granted ID on every accepted transfer and holds otherwise.
- Write stage: the accepted addr/data register into rf_waddr/rf_wdata at the accepting edge. rf_we=1 for exactly the following cycle. Latency is 1 cycle from acceptance to rf_we.
  - The stage never back-pressures, so one write per cycle is sustained.
  - When no transfer is accepted, rf_we=0 next cycle and rf_waddr/rf_wdata hold.
- Register 0: a request to address 0 is accepted normally, but rf_we stays 0 for it and last_grant still updates.
- Scoreboard:
  - busy[i] sets at the edge where rsv_valid=1 and rsv_addr=i, for i≠0.
  - busy[i] clears at the edge ending a cycle where rf_we=1 and rf_waddr=i, i.e. once the value is in the file.
  - Set and clear on the same address in the same cycle: set wins.
  - busy[0] is constant 0.
  - A write to an unreserved register is legal and leaves busy unchanged.
- hazard = busy[chk_addr1] | busy[chk_addr2], from registered busy only. A same-cycle rsv does not affect it.
- Reset mid-transfer: any in-flight rf_we is dropped. The requester sees ready=0 and must re-present after reset.

Decomposition:
- Shared package regfile_pkg: AW, DW, NREG; requester IDs REQ_ALU=0, REQ_MEM=1; typedef for the write request (addr, data).
- Sub-module rr_arb2: two-input round-robin arbiter holding last_grant, inputs req[1:0]/accept, output gnt[1:0]. The top module holds the write stage and the scoreboard.

Test Plan:
1. Reset release, no stimulus -> rf_we=0, busy=0, hazard=0, both readies 0 while rst=1.
2. alu_valid with waddr=5, wdata=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
3. Both valid for 4 cycles (ALU addr 1-4, MEM addr 11-14) -> grants alternate ALU,MEM,ALU,MEM, ALU first after reset; rf_waddr sequence 1,11,2,12.
4. rsv addr 7, then chk_addr1=7 -> hazard=1. MEM write to 7 accepted at cycle t -> rf_we at t+1, busy[7]=0 and hazard=0 at t+2. Reserving 7 in the cycle rf_we writes 7 leaves busy[7]=1.
5. ALU write to addr 0 with data 0x1234 -> alu_ready=1, rf_we stays 0; rsv addr 0 -> busy stays 0.
6. Assert rst while rf_we=1 and busy[9]=1 -> rf_we, busy and readies go 0 immediately, before any clock edge; after release the first tie is granted to ALU.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
package regfile_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    // Requester IDs double as bit positions in the arbiter request/grant vectors
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win the
// most recent accepted transfer gets the grant.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    req_id_e r_last_grant;

    // Combinational grant: single requester wins outright, tie goes to the non-last
    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (r_last_grant == REQ_MEM) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    // Remember who won the last accepted transfer; MEM after reset so ALU wins first tie
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= REQ_MEM;
        end else if (i_accept) begin
            r_last_grant <= o_gnt[1] ? REQ_MEM : REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: arbitrates ALU and load results onto the register
// file's single write port through a one-cycle registered write stage, and
// tracks reserved-but-not-yet-written destinations for hazard detection.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [AW-1:0]   i_alu_waddr,
    input  logic [DW-1:0]   i_alu_wdata,
    input  logic            i_mem_valid,
    output logic            o_mem_ready,
    input  logic [AW-1:0]   i_mem_waddr,
    input  logic [DW-1:0]   i_mem_wdata,
    input  logic            i_rsv_valid,
    input  logic [AW-1:0]   i_rsv_addr,
    input  logic [AW-1:0]   i_chk_addr1,
    input  logic [AW-1:0]   i_chk_addr2,
    output logic            o_hazard,
    output logic            o_rf_we,
    output logic [AW-1:0]   o_rf_waddr,
    output logic [DW-1:0]   o_rf_wdata,
    output logic [NREG-1:0] o_busy
);

    logic [1:0]      w_gnt;
    logic            w_accept;
    wr_req_t         w_win;

    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    ({i_mem_valid, i_alu_valid}),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    // Readies are held low during reset so nothing can be accepted across it
    assign o_alu_ready = w_gnt[REQ_ALU] & ~i_rst;
    assign o_mem_ready = w_gnt[REQ_MEM] & ~i_rst;
    assign w_accept    = o_alu_ready | o_mem_ready;

    // Select the winning requester's address and data
    always_comb begin
        w_win = '{addr: i_alu_waddr, data: i_alu_wdata};
        if (o_mem_ready) begin
            w_win = '{addr: i_mem_waddr, data: i_mem_wdata};
        end
    end

    // Write stage: capture the accepted request; writes to register 0 are swallowed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_accept && (w_win.addr != '0);
            if (w_accept) begin
                r_waddr <= w_win.addr;
                r_wdata <= w_win.data;
            end
        end
    end

    // Scoreboard next state: retire the register being written, then apply a reservation
    always_comb begin
        w_busy_next = r_busy;
        if (r_we) begin
            w_busy_next[r_waddr] = 1'b0;
        end
        // Applied after the clear so a same-address reservation wins
        if (i_rsv_valid) begin
            w_busy_next[i_rsv_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Hazard looks only at registered state; same-cycle reservations are not visible
    assign o_hazard   = r_busy[i_chk_addr1] | r_busy[i_chk_addr2];
    assign o_rf_we    = r_we;
    assign o_rf_waddr = r_waddr;
    assign o_rf_wdata = r_wdata;
    assign o_busy     = r_busy;

endmodule
